// File: rtl/ksa_if.sv
// ARC4 key-scheduling control and S-memory port bundle.
// Signals: en/rdy start handshake, 24-bit key, 8-bit S memory port (addr, rddata, wrdata, wren).
// master = requester + memory side; slave = ksa engine side.
interface ksa_if;
  logic        en;      // start request, accepted only while rdy=1
  logic        rdy;     // engine idle and able to accept en
  logic [23:0] key;     // byte0=key[23:16], byte1=key[15:8], byte2=key[7:0]
  logic [7:0]  addr;    // S memory address
  logic [7:0]  rddata;  // S memory read data, valid the cycle after addr
  logic [7:0]  wrdata;  // S memory write data
  logic        wren;    // S memory write enable

  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );

  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: in-place 256-iteration swap loop over a 256x8 S memory preset to S[i]=i.
// Latency: 5 cycles per iteration, 1280 busy cycles per run; rdy returns 1280 edges after en is accepted.
// Backpressure: en is only taken while rdy=1; en during a run is ignored, nothing is queued.
// Ports: clk, rst (sync, active-high), bus (ksa_if.slave: en/rdy/key handshake + addr/rddata/wrdata/wren).
module ksa (
  input  logic   clk,
  input  logic   rst,
  ksa_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    CALC_J,
    RD_J,
    WR_I,
    WR_J
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  k_q, k_d;      // i mod 3, kept as a wrapping counter
  logic [7:0]  si_q, si_d;    // S[i] as read in CALC_J
  logic [7:0]  sj_q, sj_d;    // S[j] as read in WR_I
  logic [23:0] key_q, key_d;  // key snapshot taken when a run starts
  logic [7:0]  key_byte;

  // Key byte for the current iteration.
  always_comb begin
    key_byte = key_q[7:0];
    case (k_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // Next-state and memory-port decode. Outputs depend only on state and
  // registers, except wrdata in WR_I which forwards rddata (S[j]) straight
  // into S[i] so no extra cycle is spent.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    key_d      = key_q;
    bus.rdy    = 1'b0;
    bus.addr   = 8'd0;
    bus.wrdata = 8'd0;
    bus.wren   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 2'd0;
          key_d   = bus.key;
          state_d = RD_I;
        end
      end

      RD_I: begin
        bus.addr = i_q;
        state_d  = CALC_J;
      end

      CALC_J: begin
        // rddata holds S[i]; the 8-bit sum wraps modulo 256 by width.
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + key_byte;
        state_d = RD_J;
      end

      RD_J: begin
        bus.addr = j_q;
        state_d  = WR_I;
      end

      WR_I: begin
        // S[j] was read before either write of this iteration, so the
        // i==j case writes the same value twice and stays correct.
        bus.addr   = i_q;
        bus.wrdata = bus.rddata;
        bus.wren   = 1'b1;
        sj_d       = bus.rddata;
        state_d    = WR_J;
      end

      WR_J: begin
        bus.addr   = j_q;
        bus.wrdata = si_q;
        bus.wren   = 1'b1;
        if (i_q == 8'd255) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
          state_d = RD_I;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 2'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  // A self-swap must read back the value it started from.
  always_ff @(posedge clk) begin
    if (!rst && state_q == WR_J && i_q == j_q) begin
      assert (sj_q == si_q);
    end
  end

  // k never reaches 3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (k_q != 2'd3);
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural ARC4 KSA model, S memory model, per-cycle write-stream compare.
// Latency checked: rdy low for exactly 1280 cycles per run, 512 writes per run.
// Stimulus: fixed and $urandom keys, mid-run key/en disturbance, mid-run reset, en held across run end.
module tb_ksa;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ksa_if bus ();

  ksa dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // S memory: 1-cycle read latency; init_req presets identity contents.
  logic [7:0] mem [256];
  logic       init_req = 1'b0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] ms [256];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         wr_cnt   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Software KSA on identity S; records the expected (addr,data) write pair
  // of every iteration: S[i] gets old S[j], then S[j] gets old S[i].
  task automatic model_run(input logic [23:0] k, input int n_iter);
    int         j;
    logic [7:0] kb [3];
    logic [7:0] t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    exp_q.delete();
    for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    j = 0;
    for (int i = 0; i < n_iter; i++) begin
      j = (j + int'(ms[i]) + int'(kb[i % 3])) % 256;
      exp_q.push_back({8'(i), ms[j]});
      exp_q.push_back({8'(j), ms[i]});
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  // Every write cycle must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.wren) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(bus.addr), int'(e.a));
        chk("wr_data", int'(bus.wrdata), int'(e.d));
      end
    end
  end

  // mode: 0 plain, 1 key change + en pulse at cycle 400, 2 reset at cycle 700,
  // 3 en held high through the end of the run.
  task automatic run(input logic [23:0] k, input int mode);
    int cnt;
    int bad;
    model_run(k, 256);
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wr_cnt   = 0;
    bus.key  = k;
    bus.en   = 1'b1;
    @(negedge clk);
    if (mode != 3) bus.en = 1'b0;
    cnt = 0;
    while (cnt < 2000) begin
      if (bus.rdy) break;
      cnt++;
      if (mode == 0 && k == 24'h0 && cnt == 21) begin
        chk("trace_S0", int'(mem[0]), 0);
        chk("trace_S1", int'(mem[1]), 1);
        chk("trace_S2", int'(mem[2]), 3);
        chk("trace_S3", int'(mem[3]), 5);
        chk("trace_S4", int'(mem[4]), 4);
        chk("trace_S5", int'(mem[5]), 2);
      end
      if (mode == 1 && cnt == 400) begin
        bus.key = 24'($urandom);
        bus.en  = 1'b1;
      end
      if (mode == 1 && cnt == 401) bus.en = 1'b0;
      if (mode == 2 && cnt == 700) begin
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", int'(bus.rdy), 1);
        chk("midrst_wren", int'(bus.wren), 0);
        chk("midrst_addr", int'(bus.addr), 0);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    chk("busy_cycles", cnt, 1280);
    chk("wren_count", wr_cnt, 512);
    chk("writes_left", exp_q.size(), 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ms[a]) bad++;
    chk("final_S_mismatches", bad, 0);
    if (mode == 3) begin
      @(posedge clk);
      #1 bus.en = 1'b0;
      @(negedge clk);
      chk("held_en_restart_rdy", int'(bus.rdy), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("held_en_abort_rdy", int'(bus.rdy), 1);
      rst = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    int idle_busy;
    bus.en  = 1'b0;
    bus.key = 24'h0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rdy", int'(bus.rdy), 1);
    chk("reset_wren", int'(bus.wren), 0);
    chk("reset_addr", int'(bus.addr), 0);
    rst    = 1'b0;
    wr_cnt = 0;
    idle_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.rdy) idle_busy++;
    end
    chk("idle_busy_cycles", idle_busy, 0);
    chk("idle_writes", wr_cnt, 0);

    // Hand-derived pins on the model.
    model_run(24'h0, 4);
    chk("model_S0", int'(ms[0]), 0);
    chk("model_S2", int'(ms[2]), 3);
    chk("model_S3", int'(ms[3]), 5);
    chk("model_S5", int'(ms[5]), 2);
    model_run(24'h0, 256);
    chk("model0_w4", int'(exp_q[4]), 16'h0203);
    chk("model0_w5", int'(exp_q[5]), 16'h0302);
    model_run(24'hFFFFFF, 256);
    chk("modelF_w0", int'(exp_q[0]), 16'h00FF);
    chk("modelF_w1", int'(exp_q[1]), 16'hFF00);
    chk("modelF_w2", int'(exp_q[2]), 16'h0100);
    chk("modelF_w3", int'(exp_q[3]), 16'hFF01);
    chk("modelF_w4", int'(exp_q[4]), 16'h02FF);
    chk("modelF_w5", int'(exp_q[5]), 16'h0002);

    run(24'h000000, 0);
    run(24'h00033C, 0);
    run(24'hFFFFFF, 3);
    run(24'($urandom), 1);
    run(24'($urandom), 2);
    run(24'h00033C, 0);
    repeat (2) run(24'($urandom), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
